// File: rtl/imem_arb_pkg.sv
// Shared types and default widths for the instruction-memory arbiter and its
// round-robin picker.
package imem_arb_pkg;

    localparam int IMEM_ADDR_W = 64;
    localparam int IMEM_INST_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Width of an index into n requesters; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Requester-side and memory-side signals of the instruction-memory arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface imem_arbiter_if
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W  = IMEM_ADDR_W,
    parameter int INST_W  = IMEM_INST_W,
    parameter int NUM_REQ = 2
);

    logic [NUM_REQ-1:0]        i_req;
    logic [NUM_REQ*ADDR_W-1:0] i_addr;
    logic [NUM_REQ-1:0]        o_ack;
    logic [NUM_REQ-1:0]        o_rvalid;
    logic [INST_W-1:0]         o_rdata;
    logic                      o_rerr;
    logic                      o_mem_valid;
    logic [ADDR_W-1:0]         o_mem_addr;
    logic                      i_mem_valid;
    logic [INST_W-1:0]         i_mem_inst;

    modport slave (
        input  i_req, i_addr, i_mem_valid, i_mem_inst,
        output o_ack, o_rvalid, o_rdata, o_rerr, o_mem_valid, o_mem_addr
    );

    modport master (
        output i_req, i_addr, i_mem_valid, i_mem_inst,
        input  o_ack, o_rvalid, o_rdata, o_rerr, o_mem_valid, o_mem_addr
    );

endinterface

// File: rtl/imem_rr_picker.sv
// Combinational round-robin picker: first set request at or cyclically after
// the pointer. Shared with the data-memory arbiter.
module imem_rr_picker
    import imem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_o
);

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return IDX_W'((v >= NUM_REQ) ? v - NUM_REQ : v);
    endfunction

    // Scanning from the farthest candidate back to the pointer lets the
    // nearest hit be the last write, so no early exit is needed.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // block leaves a value unassigned, which would infer a latch.
        grant_idx_o = '0;
        any_o       = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[wrap_idx(int'(ptr_i) + i)]) begin
                any_o       = 1'b1;
                grant_idx_o = wrap_idx(int'(ptr_i) + i);
            end
        end
        grant_o = any_o ? (NUM_REQ'(1) << grant_idx_o) : '0;
    end

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle instruction memory.
// Define IMEM_ARB_TIMEOUT_EN to add a WAIT-state watchdog that returns o_rerr.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W      = IMEM_ADDR_W,
    parameter int INST_W      = IMEM_INST_W,
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    imem_arbiter_if.slave bus
);

    localparam int IDX_W = idx_w(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("imem_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYC >= 1");
    end

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
    logic [INST_W-1:0]   rdata_q, rdata_d;
    logic                rerr_q, rerr_d;
    logic                mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic                timeout_hit;

    imem_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i       (bus.i_req),
        .ptr_i       (rr_q),
        .grant_o     (pick_onehot),
        .grant_idx_o (pick_idx),
        .any_o       (pick_any)
    );

    assign grant_onehot = NUM_REQ'(1) << grant_q;

`ifdef IMEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wdog_q, wdog_d;

    // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
    assign wdog_d      = (state_q == ST_WAIT) ? wdog_q + CNT_W'(1) : '0;
    assign timeout_hit = (state_q == ST_WAIT) && (wdog_d == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) wdog_q <= '0;
        else          wdog_q <= wdog_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        ack_d       = '0;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        rerr_d      = 1'b0;
        mem_valid_d = 1'b0;
        mem_addr_d  = mem_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d     = pick_idx;
                    ack_d       = pick_onehot;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = bus.i_addr[pick_idx*ADDR_W +: ADDR_W];
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // A response landing on the watchdog limit still counts as good.
                if (bus.i_mem_valid) begin
                    rvalid_d = grant_onehot;
                    rdata_d  = bus.i_mem_inst;
                    state_d  = ST_RESP;
                end else if (timeout_hit) begin
                    rvalid_d = grant_onehot;
                    rdata_d  = '0;
                    rerr_d   = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                rr_d    = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            ack_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            rerr_q      <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            ack_q       <= ack_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rerr_q      <= rerr_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign bus.o_ack       = ack_q;
    assign bus.o_rvalid    = rvalid_q;
    assign bus.o_rdata     = rdata_q;
    assign bus.o_rerr      = rerr_q;
    assign bus.o_mem_valid = mem_valid_q;
    assign bus.o_mem_addr  = mem_addr_q;

endmodule
